// File: rtl/binary_window_gen_if.sv
// Pixel-in / window-out stream bundle for binary_window_gen.
// The master drives pixels and observes windows; the slave is the generator.
interface binary_window_gen_if;
  logic       pixel_valid;
  logic       pixel_bit;
  logic       frame_start;
  logic       window_valid;
  logic [8:0] binary_window;

  modport master (
    output pixel_valid, pixel_bit, frame_start,
    input  window_valid, binary_window
  );

  modport slave (
    input  pixel_valid, pixel_bit, frame_start,
    output window_valid, binary_window
  );
endinterface

// File: rtl/binary_window_gen.sv
// Streaming 3x3 window generator for 1-bit raster images, two line buffers deep.
// Optional BWIN_COORD_EN adds win_x/win_y outputs carrying the window centre.
module binary_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                          clk,
  input  logic                          rst_n,
  binary_window_gen_if.slave            pix
`ifdef BWIN_COORD_EN
  ,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_y
`endif
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_MAX = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_HEIGHT - 1);

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;

  // lb0 holds row y-1, lb1 holds row y-2; never reset
  logic lb0 [0:IMG_WIDTH-1];
  logic lb1 [0:IMG_WIDTH-1];
  logic lb0_rd;
  logic lb1_rd;

  // stored columns x-2 (col_l) and x-1 (col_c), packed {bottom, mid, top}
  logic [2:0] col_l;
  logic [2:0] col_c;
  logic       qualify;
  logic [8:0] window_next;

  always_comb begin
    cur_x       = pix.frame_start ? '0 : x_q;
    cur_y       = pix.frame_start ? '0 : y_q;
    lb0_rd      = lb0[cur_x];
    lb1_rd      = lb1[cur_x];
    qualify     = pix.pixel_valid && (cur_x >= XW'(2)) && (cur_y >= YW'(2));
    window_next = {pix.pixel_bit, col_c[2], col_l[2],
                   lb0_rd,        col_c[1], col_l[1],
                   lb1_rd,        col_c[0], col_l[0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (pix.pixel_valid) begin
      if (cur_x == X_MAX) begin
        x_q <= '0;
        y_q <= (cur_y == Y_MAX) ? '0 : cur_y + YW'(1);
      end else begin
        x_q <= cur_x + XW'(1);
        y_q <= cur_y;
      end
    end
  end

  // read-before-write: lb1 takes the value lb0 held before this pixel overwrites it
  always_ff @(posedge clk) begin
    if (pix.pixel_valid) begin
      lb1[cur_x] <= lb0_rd;
      lb0[cur_x] <= pix.pixel_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_l <= '0;
      col_c <= '0;
    end else if (pix.pixel_valid) begin
      col_l <= col_c;
      col_c <= {pix.pixel_bit, lb0_rd, lb1_rd};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix.window_valid  <= 1'b0;
      pix.binary_window <= '0;
    end else begin
      pix.window_valid <= qualify;
      if (qualify) begin
        pix.binary_window <= window_next;
      end
    end
  end

`ifdef BWIN_COORD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_x <= '0;
      win_y <= '0;
    end else if (qualify) begin
      win_x <= cur_x - XW'(1);
      win_y <= cur_y - YW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_binary_window_gen.sv
// Scoreboard bench for binary_window_gen on a 5x4 image.
module tb_binary_window_gen;
  localparam int W = 5;
  localparam int H = 4;

  typedef struct {
    logic [8:0] win;
    int         cx;
    int         cy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  binary_window_gen_if pif ();
`ifdef BWIN_COORD_EN
  logic [$clog2(W)-1:0] win_x;
  logic [$clog2(H)-1:0] win_y;
`endif

  binary_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pix   (pif.slave)
`ifdef BWIN_COORD_EN
    ,
    .win_x (win_x),
    .win_y (win_y)
`endif
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  int         win_cnt = 0;
  int         mx = 0;
  int         my = 0;
  logic       img [0:H-1][0:W-1];
  exp_t       exp_q [$];
  logic [8:0] obs [$];
  logic       acc_at_edge;

  // reference: window over rows my-2..my, cols mx-2..mx of the model image
  task automatic send(input logic b, input logic fs);
    exp_t e;
    @(negedge clk);
    pif.pixel_valid = 1'b1;
    pif.pixel_bit   = b;
    pif.frame_start = fs;
    if (fs) begin
      mx = 0;
      my = 0;
    end
    img[my][mx] = b;
    if (mx >= 2 && my >= 2) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          e.win[r*3+c] = img[my-2+r][mx-2+c];
      e.cx = mx - 1;
      e.cy = my - 1;
      exp_q.push_back(e);
    end
    if (mx == W-1) begin
      mx = 0;
      my = (my == H-1) ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    pif.pixel_valid = 1'b0;
    pif.frame_start = 1'b0;
  endtask

  task automatic settle();
    idle();
    @(posedge clk);
    #3;
  endtask

  // kind: 0 = single 1 at (2,1), 1 = all ones, 2 = random
  task automatic send_frame(input int kind, input bit gapped);
    logic b;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        b = (kind == 0) ? logic'(x == 2 && y == 1) :
            (kind == 1) ? 1'b1 : logic'($urandom_range(0, 1));
        send(b, 1'b0);
        if (gapped) idle();
      end
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    acc_at_edge = pif.pixel_valid;
    #1;
    if (rst_n && pif.window_valid) begin
      win_cnt++;
      obs.push_back(pif.binary_window);
      vectors++;
      if (!acc_at_edge) begin
        miscompares++;
        $display("FAIL valid_without_input: window_valid=1 after idle input cycle, required 0");
      end else if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_window: got %h with no window expected", pif.binary_window);
      end else begin
        e = exp_q.pop_front();
        if (pif.binary_window !== e.win) begin
          miscompares++;
          $display("FAIL window_data: got %h, required %h (centre %0d,%0d)",
                   pif.binary_window, e.win, e.cx, e.cy);
        end
`ifdef BWIN_COORD_EN
        vectors++;
        if (int'(win_x) != e.cx || int'(win_y) != e.cy) begin
          miscompares++;
          $display("FAIL window_coord: got (%0d,%0d), required (%0d,%0d)",
                   win_x, win_y, e.cx, e.cy);
        end
`endif
      end
    end
  end

  task automatic check_drained(input string name, input int base, input int want);
    vectors++;
    if (win_cnt - base != want || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_count: got %0d windows (%0d pending), required %0d",
               name, win_cnt - base, exp_q.size(), want);
    end
  endtask

  task automatic test_reset();
    int base;
    #3;
    vectors++;
    if (pif.window_valid !== 1'b0 || pif.binary_window !== 9'h000) begin
      miscompares++;
      $display("FAIL reset_initial: valid=%b win=%h, required 0/000",
               pif.window_valid, pif.binary_window);
    end
    @(negedge clk);
    rst_n = 1'b1;
    base = win_cnt;
    for (int i = 0; i < 2*W+3; i++) send(1'b1, 1'b0);
    settle();
    check_drained("pre_reset", base, 1);
    vectors++;
    if (pif.binary_window !== 9'h1FF) begin
      miscompares++;
      $display("FAIL pre_reset_window: got %h, required 1ff", pif.binary_window);
    end
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0);
    @(negedge clk);
    pif.pixel_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (pif.window_valid !== 1'b0 || pif.binary_window !== 9'h000) begin
      miscompares++;
      $display("FAIL reset_async: valid=%b win=%h, required 0/000",
               pif.window_valid, pif.binary_window);
    end
    exp_q.delete();
    mx = 0;
    my = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_pixel();
    int base = win_cnt;
    obs.delete();
    send_frame(0, 1'b0);
    settle();
    check_drained("single_pixel", base, 6);
    vectors++;
    if (obs.size() != 6) begin
      miscompares++;
      $display("FAIL single_pixel_obs: got %0d windows, required 6", obs.size());
    end else begin
      vectors++;
      if (obs[0] !== 9'h020 || obs[1] !== 9'h010 || obs[5] !== 9'h001) begin
        miscompares++;
        $display("FAIL single_pixel_values: got %h %h %h, required 020 010 001",
                 obs[0], obs[1], obs[5]);
      end
    end
  endtask

  task automatic test_all_ones();
    int base = win_cnt;
    send_frame(1, 1'b0);
    settle();
    check_drained("all_ones", base, (W-2)*(H-2));
  endtask

  task automatic test_gapped();
    int base = win_cnt;
    send_frame(2, 1'b1);
    settle();
    check_drained("gapped", base, (W-2)*(H-2));
  endtask

  task automatic test_frame_restart();
    int base = win_cnt;
    for (int i = 0; i < 2*W+3; i++) send(logic'($urandom_range(0, 1)), 1'b0);
    settle();
    check_drained("restart_pre", base, 1);
    base = win_cnt;
    send(logic'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 2*W+1; i++) send(logic'($urandom_range(0, 1)), 1'b0);
    settle();
    check_drained("restart_quiet", base, 0);
    send(logic'($urandom_range(0, 1)), 1'b0);
    settle();
    check_drained("restart_first", base, 1);
    for (int i = 0; i < W*H - (2*W+3); i++) send(logic'($urandom_range(0, 1)), 1'b0);
    settle();
    check_drained("restart_rest", base, (W-2)*(H-2));
  endtask

  task automatic test_back_to_back();
    int base = win_cnt;
    send_frame(2, 1'b0);
    send_frame(2, 1'b0);
    settle();
    check_drained("back_to_back", base, 2*(W-2)*(H-2));
  endtask

  initial begin
    pif.pixel_valid = 1'b0;
    pif.pixel_bit   = 1'b0;
    pif.frame_start = 1'b0;
    test_reset();
    test_single_pixel();
    test_all_ones();
    test_gapped();
    test_frame_restart();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end
endmodule
